// File: rtl/i2c_reg_arbiter.sv
// i2c_reg_arbiter
//   Shares one single-port register bus (8-bit address, 16-bit data) between
//   an I2C slave register port and a local host port.
//   The I2C side has no handshake. Its writes are held in a one-deep buffer.
//   Read data for the current i2c_addr is prefetched continuously into
//   i2c_rdata.
//   Fixed, non-preemptive priority, decided in IDLE only:
//     pending I2C write > stale prefetch refresh > host request.
//
// Parameters
//   READ_LATENCY  cycles from the bus_en cycle until bus_rdata is valid (1..3)
//
// Ports
//   clk, reset                 clock; asynchronous active-high reset
//   i2c_we/addr/wdata          one-cycle write pulse, address and data
//   i2c_busy                   slave transaction in progress
//   i2c_rdata                  prefetched read data for i2c_addr
//   i2c_overrun                sticky: a write was dropped because the buffer was full
//   host_req/we/addr/wdata     host request, held until host_ack
//   host_ack/rdata             one-cycle completion pulse and read data
//   bus_en/we/addr/wdata       bus access strobe (one cycle per access) and qualifiers
//   bus_rdata                  bus read data
//
// Optional build macro
//   I2C_REG_ARBITER_HOST_LOCKOUT_EN  holds off new host grants while i2c_busy=1
module i2c_reg_arbiter #(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i2c_we,
  input  logic [7:0]  i2c_addr,
  input  logic [15:0] i2c_wdata,
  input  logic        i2c_busy,
  output logic [15:0] i2c_rdata,
  output logic        i2c_overrun,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [7:0]  host_addr,
  input  logic [15:0] host_wdata,
  output logic        host_ack,
  output logic [15:0] host_rdata,
  output logic        bus_en,
  output logic        bus_we,
  output logic [7:0]  bus_addr,
  output logic [15:0] bus_wdata,
  input  logic [15:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic [1:0] {OWN_I2C, OWN_REFRESH, OWN_HOST} owner_t;

  state_t      state, state_n;
  owner_t      owner;
  logic        op_we;
  logic [1:0]  cnt;

  logic        pend;
  logic [7:0]  pend_addr;
  logic [15:0] pend_data;

  logic [7:0]  fetch_addr;
  logic        fetch_valid;

  logic        stale;
  logic        host_go;
  logic        sel_i2c, sel_ref, sel_host;
  logic        pend_clr;

  assign stale = !fetch_valid || (i2c_addr != fetch_addr);

`ifdef I2C_REG_ARBITER_HOST_LOCKOUT_EN
  // Keep multi-byte I2C transfers atomic; an access already issued still completes.
  assign host_go = host_req && !i2c_busy;
`else
  logic unused_busy;
  assign unused_busy = i2c_busy;
  assign host_go     = host_req;
`endif

  // The buffered I2C write retires in its ISSUE cycle.
  assign pend_clr = (state == ISSUE) && (owner == OWN_I2C);

  assign bus_en = (state == ISSUE);
  assign bus_we = bus_en && op_we;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    sel_i2c  = 1'b0;
    sel_ref  = 1'b0;
    sel_host = 1'b0;
    case (state)
      IDLE: begin
        if (pend) begin
          sel_i2c = 1'b1;
        end else if (stale) begin
          sel_ref = 1'b1;
        end else if (host_go) begin
          sel_host = 1'b1;
        end
        if (pend || stale || host_go) begin
          state_n = ISSUE;
        end
      end
      ISSUE:   state_n = op_we ? DONE : WAIT;
      WAIT:    if (cnt == '0) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Transaction datapath: grant latch, read capture, prefetch status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner       <= OWN_I2C;
      op_we       <= 1'b0;
      cnt         <= '0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      i2c_rdata   <= '0;
      host_rdata  <= '0;
      host_ack    <= 1'b0;
      fetch_addr  <= '0;
      fetch_valid <= 1'b0;
    end else begin
      host_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_i2c) begin
            owner     <= OWN_I2C;
            op_we     <= 1'b1;
            bus_addr  <= pend_addr;
            bus_wdata <= pend_data;
          end else if (sel_ref) begin
            owner    <= OWN_REFRESH;
            op_we    <= 1'b0;
            bus_addr <= i2c_addr;
          end else if (sel_host) begin
            owner     <= OWN_HOST;
            op_we     <= host_we;
            bus_addr  <= host_addr;
            bus_wdata <= host_wdata;
          end
        end
        ISSUE: begin
          if (op_we) begin
            if (owner == OWN_HOST) begin
              host_ack <= 1'b1;
            end
            if (bus_addr == fetch_addr) begin
              fetch_valid <= 1'b0;
            end
          end else begin
            cnt <= 2'(READ_LATENCY - 1);
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            // Data is filed under the address actually issued; a moved
            // i2c_addr simply shows up as stale again.
            if (owner == OWN_REFRESH) begin
              i2c_rdata   <= bus_rdata;
              fetch_addr  <= bus_addr;
              fetch_valid <= 1'b1;
            end else begin
              host_rdata <= bus_rdata;
              host_ack   <= 1'b1;
            end
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // One-deep I2C write buffer. A write landing in the retire cycle is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend        <= 1'b0;
      pend_addr   <= '0;
      pend_data   <= '0;
      i2c_overrun <= 1'b0;
    end else begin
      if (i2c_we) begin
        if (pend && !pend_clr) begin
          i2c_overrun <= 1'b1;
        end else begin
          pend      <= 1'b1;
          pend_addr <= i2c_addr;
          pend_data <= i2c_wdata;
        end
      end else if (pend_clr) begin
        pend <= 1'b0;
      end
    end
  end

endmodule

// File: doc/i2c_reg_arbiter.md
Name: i2c_reg_arbiter

Overview:
- Shares one single-port 16-bit, 8-bit-addressed register bus between two requesters.
- Requester 1 is the I2C slave register port; requester 2 is a local host port.
- The I2C port has no handshake, so writes are buffered one deep and read data is prefetched continuously for the current I2C address.
- Sits between the I2C slave and the register file/RAM.

Parameters:
- READ_LATENCY, 1, cycles from the bus_en cycle until bus_rdata is valid; legal range 1..3.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- i2c_we  in  1  one-cycle write pulse from the slave
- i2c_addr  in  8  slave register address
- i2c_wdata  in  16  slave write data, valid with i2c_we
- i2c_busy  in  1  slave transaction in progress
- i2c_rdata  out  16  prefetched read data for i2c_addr
- i2c_overrun  out  1  sticky: an i2c_we arrived while the write buffer was full
- host_req  in  1  host request, held until host_ack
- host_we  in  1  1 = write, 0 = read; valid with host_req
- host_addr  in  8  host address
- host_wdata  in  16  host write data
- host_ack  out  1  one-cycle completion pulse
- host_rdata  out  16  read data, valid in the host_ack cycle
- bus_en  out  1  bus access strobe, high for one cycle per access
- bus_we  out  1  write qualifier for bus_en
- bus_addr  out  8  bus address
- bus_wdata  out  16  bus write data
- bus_rdata  in  16  bus read data

Behaviour:
- Reset (asynchronous, any state) sets every output to 0 and returns the FSM to IDLE.
- Reset also clears the write buffer, the prefetch-valid flag, fetch_addr and i2c_overrun. A refresh therefore follows release of reset.
- I2C write buffer:
  - i2c_we loads pend_addr/pend_data and sets pend.
  - If pend is already set and not being cleared in the same cycle, set i2c_overrun and drop the new write.
- Prefetch status:
  - fetch_addr and a valid flag record which address i2c_rdata holds.
  - stale = !valid OR i2c_addr != fetch_addr.
  - Any completed write (either port) whose address equals fetch_addr clears valid.
- Priority, evaluated in IDLE only: pend write > stale refresh > host_req. Priority is fixed and non-preemptive.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: select the winner, latch owner/addr/data into bus registers, go to ISSUE. With no request, stay in IDLE.
- ISSUE:
  - bus_en=1, bus_we per the operation.
  - Write: clear pend (I2C) or pulse host_ack next cycle (host), then go to DONE.
  - Read: go to WAIT with counter = READ_LATENCY-1.
- WAIT:
  - Decrement the counter. When the counter is 0, capture bus_rdata.
  - Refresh read: capture into i2c_rdata, set fetch_addr = the address issued, set valid.
  - Host read: capture into host_rdata and pulse host_ack.
  - Then go to DONE.
- DONE: one idle bus cycle, then IDLE. host_req still high in DONE/IDLE after host_ack counts as a new request.
- If i2c_addr changes during a refresh, the captured data is still stored against the issued address. stale re-asserts and a new refresh follows.
- Worst-case I2C write wait: one host access (READ_LATENCY+3 cycles) plus one refresh. This is far below one I2C byte time, so a single-entry buffer suffices.
- Same-cycle i2c_we and pend clear: the new write is accepted and no overrun is flagged.
- bus_en is never high on two consecutive cycles.

Optional Feature:
- Macro: I2C_REG_ARBITER_HOST_LOCKOUT_EN.
- Defined: host_req is not granted while i2c_busy=1, so multi-byte I2C transfers see atomic register contents. A host access already in ISSUE/WAIT completes normally.
- Undefined: host accesses interleave freely with I2C activity, subject to the priority order.

Test Plan:
- Release reset with i2c_addr=0x10 and mem[0x10]=0xBEEF (READ_LATENCY=1) -> one read bus_en at 0x10; i2c_rdata=0xBEEF within 5 cycles; no further bus_en.
- i2c_we addr=0x22 data=0x1234 -> bus write 0x22/0x1234 within 6 cycles; i2c_overrun stays 0.
- Two i2c_we pulses 2 cycles apart while a host read is in WAIT -> second write dropped; i2c_overrun=1 until reset.
- Host read 0x05 (mem=0xA5A5) concurrent with i2c_addr change -> refresh wins; host_ack arrives later with host_rdata=0xA5A5.
- Host write 0x10=0x5555 while fetch_addr=0x10 -> a refresh re-reads 0x10; i2c_rdata=0x5555.
- With HOST_LOCKOUT_EN, i2c_busy=1 and host_req=1 -> no host_ack until i2c_busy falls; then ack within READ_LATENCY+3 cycles.
